// File: rtl/mul_pkg.sv
`default_nettype none
// ---- mul_pkg: state encoding and width helpers for the sequential multiplier ----
// ---- rev 1.0 ----
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Product and iteration-counter widths derived from the operand width.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_cond_neg.sv
`default_nettype none
// ---- mul_cond_neg: combinational conditional two's-complement negate ----
// ---- rev 1.0 ----
module mul_cond_neg
  import mul_pkg::*;
#(
  parameter int w = 6
) (
  input  logic [w-1:0] in_val,
  input  logic         neg,
  output logic [w-1:0] out_val
);

  assign out_val = neg ? (~in_val + w'(1)) : in_val;

endmodule
`default_nettype wire

// File: rtl/mul_top.sv
`default_nettype none
// ---- mul_top: shift-add multiplier, one multiplier bit per clock; MUL_SIGNED_EN adds signed operands ----
// ---- rev 1.0 ----
module mul_top
  import mul_pkg::*;
#(
  parameter int width = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sign,
  input  logic [width-1:0]       multiplicand,
  input  logic [width-1:0]       multiplier,
  output logic [2*width-1:0]     product,
  output logic                   ready,
  output logic                   done
);

  localparam int PROD_W = prod_w(width);
  localparam int CNT_W  = cnt_w(width);

  mul_state_t        state;
  logic [PROD_W-1:0] a_mag;
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] acc_next;
  logic [PROD_W-1:0] prod_fix;
  logic [width-1:0]  b_mag;
  logic [width-1:0]  a_in_mag;
  logic [width-1:0]  b_in_mag;
  logic [CNT_W-1:0]  count;
  logic              neg;
  logic              neg_in;

`ifdef MUL_SIGNED_EN
  assign neg_in = sign & (multiplicand[width-1] ^ multiplier[width-1]);

  mul_cond_neg #(.w(width)) u_neg_a (
    .in_val  (multiplicand),
    .neg     (sign & multiplicand[width-1]),
    .out_val (a_in_mag)
  );

  mul_cond_neg #(.w(width)) u_neg_b (
    .in_val  (multiplier),
    .neg     (sign & multiplier[width-1]),
    .out_val (b_in_mag)
  );

  mul_cond_neg #(.w(PROD_W)) u_neg_p (
    .in_val  (acc_next),
    .neg     (neg),
    .out_val (prod_fix)
  );
`else
  logic [1:0] unused_bits;
  assign unused_bits = {sign, neg};
  assign neg_in      = 1'b0;
  assign a_in_mag    = multiplicand;
  assign b_in_mag    = multiplier;
  assign prod_fix    = acc_next;
`endif

  // Magnitudes are bounded by 2^(width-1) or 2^width-1, so the sum never carries out.
  assign acc_next = acc + (b_mag[0] ? a_mag : '0);
  assign ready    = (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_mag   <= '0;
      b_mag   <= '0;
      acc     <= '0;
      count   <= '0;
      neg     <= 1'b0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_mag <= {{width{1'b0}}, a_in_mag};
            b_mag <= b_in_mag;
            neg   <= neg_in;
            acc   <= '0;
            count <= CNT_W'(width);
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_next;
          a_mag <= a_mag << 1;
          b_mag <= b_mag >> 1;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            product <= prod_fix;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_top.sv
`default_nettype none
// ---- tb_mul_top: randomized self-checking bench for mul_top against an arithmetic reference ----
// ---- rev 1.0 ----
module tb_mul_top;

  localparam int W  = 6;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          sign = 1'b0;
  logic [W-1:0]  multiplicand = '0;
  logic [W-1:0]  multiplier = '0;
  logic [PW-1:0] product;
  logic          ready;
  logic          done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_top #(.width(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .sign         (sign),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .ready        (ready),
    .done         (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands as integers and multiply; signedness only when compiled in.
  function automatic logic [PW-1:0] ref_mul(input logic s, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    longint va;
    longint vb;
`ifndef MUL_SIGNED_EN
    s = 1'b0;
`endif
    va = longint'(a);
    vb = longint'(b);
    if (s) begin
      if (a[W-1]) va = va - (longint'(1) << W);
      if (b[W-1]) vb = vb - (longint'(1) << W);
    end
    return PW'(va * vb);
  endfunction

  // Called with ready=1, just after a rising edge or mid-cycle before the accepting edge.
  task automatic run_op(input string tag, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int n;
    logic [PW-1:0] exp;
    exp = ref_mul(s, a, b);
    start = 1'b1;
    sign = s;
    multiplicand = a;
    multiplier = b;
    @(posedge clk); #1;
    start = 1'b0;
    sign = 1'($urandom);
    multiplicand = W'($urandom);
    multiplier = W'($urandom);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(W));
    check({tag, " product"}, 64'(product), 64'(exp));
  endtask

  logic [W-1:0]  bb_a [3];
  logic [W-1:0]  bb_b [3];
  logic          bb_s [3];

  initial begin
    int n;
    int dones;
    int done_at;
    int k;
    int last;

    #2 rst_n = 1'b0;
    #1;
    check("reset product", 64'(product), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset ready", 64'(ready), 64'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("u63x63", 1'b0, 6'd63, 6'd63);
    check("u63x63 const", 64'(product), 64'h0F81);
    run_op("s_extreme", 1'b1, 6'b100000, 6'b100000);
    check("s_extreme const", 64'(product), 64'h0400);
    run_op("s_mixed", 1'b1, 6'b111011, 6'd7);
    run_op("u_mixed", 1'b0, 6'b111011, 6'd7);
    check("u_mixed const", 64'(product), 64'h019D);

    // Zero operand plus a start pulse mid-RUN that must be ignored.
    start = 1'b1;
    sign = 1'b0;
    multiplicand = 6'd0;
    multiplier = 6'd45;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    dones = 0;
    done_at = -1;
    repeat (14) begin
      if (n == 2) begin
        start = 1'b1;
        multiplicand = 6'd63;
        multiplier = 6'd63;
      end else if (n == 3) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (done) begin
        dones++;
        done_at = n;
      end
    end
    check("busy done count", 64'(dones), 64'(1));
    check("busy done latency", 64'(done_at), 64'(W));
    check("busy product", 64'(product), 64'(0));
    check("busy idle ready", 64'(ready), 64'(1));

    // Back-to-back with start held high.
    for (int i = 0; i < 3; i++) begin
      bb_a[i] = W'($urandom);
      bb_b[i] = W'($urandom);
      bb_s[i] = 1'($urandom);
    end
    start = 1'b1;
    sign = bb_s[0];
    multiplicand = bb_a[0];
    multiplier = bb_b[0];
    @(posedge clk); #1;
    k = 0;
    n = 0;
    last = 0;
    while (k < 3 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        check("b2b product", 64'(product), 64'(ref_mul(bb_s[k], bb_a[k], bb_b[k])));
        check("b2b spacing", 64'(n - last), (k == 0) ? 64'(W) : 64'(W + 1));
        last = n;
        k++;
        if (k < 3) begin
          sign = bb_s[k];
          multiplicand = bb_a[k];
          multiplier = bb_b[k];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b completions", 64'(k), 64'(3));
    @(posedge clk); #1;

    // Reset in the middle of an operation.
    start = 1'b1;
    sign = 1'b0;
    multiplicand = 6'd21;
    multiplier = 6'd42;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst product", 64'(product), 64'(0));
    check("midrst done", 64'(done), 64'(0));
    check("midrst ready", 64'(ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 1'b1, 6'd13, 6'b110010);

    for (int i = 0; i < 30; i++) begin
      run_op("rand", 1'($urandom), W'($urandom), W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
